// File: rtl/lfsr_led_generator_pkg.sv
// Shared LFSR constants: default tap masks per width
// and helpers for the LED selector field layout.
package lfsr_pkg;

  localparam logic [63:0] TAPS_8  = 64'h0000_0000_0000_00B8;
  localparam logic [63:0] TAPS_16 = 64'h0000_0000_0000_B400;
  localparam logic [63:0] TAPS_31 = 64'h0000_0000_4800_0000;
  localparam logic [63:0] TAPS_32 = 64'h0000_0000_8020_0003;

  localparam int LED_N = 8;

  function automatic logic [63:0] default_taps(input int width);
    logic [63:0] t;
    case (width)
      8:       t = TAPS_8;
      16:      t = TAPS_16;
      31:      t = TAPS_31;
      32:      t = TAPS_32;
      default: t = 64'h3 << (width - 2);
    endcase
    return t;
  endfunction

  function automatic int sel_w(input int width);
    return $clog2(width);
  endfunction

  // LED i shows state bit i, fields packed at sel_w stride
  function automatic logic [47:0] default_sel(input int width);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < LED_N; i++) begin
      r = r | (48'(i) << (i * sel_w(width)));
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr_led_generator_if.sv
// Control/status bundle between the LFSR LED block
// and whatever drives it.
interface lfsr_led_generator_if #(
  parameter int WIDTH = 31
);
  logic             i_run;
  logic             i_step;
  logic             i_load;
  logic [WIDTH-1:0] i_seed;
  logic [7:0]       LED;
  logic [WIDTH-1:0] o_state;
  logic             o_tick;
  logic             o_lockup;
  logic [31:0]      o_count;

  modport master (
    output i_run, i_step, i_load, i_seed,
    input  LED, o_state, o_tick, o_lockup, o_count
  );

  modport slave (
    input  i_run, i_step, i_load, i_seed,
    output LED, o_state, o_tick, o_lockup, o_count
  );
endinterface

// File: rtl/tick_prescaler.sv
// Free-running divider: one-cycle tick at terminal
// count, frozen while disabled.
module tick_prescaler #(
  parameter int DIV = 25_000_000
) (
  input  logic CLK_50M,
  input  logic RST,
  input  logic i_en,
  output logic o_tick
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // gated by i_en so a frozen terminal count never re-fires
  assign o_tick = i_en & (cnt == LAST);

  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (i_en) begin
      cnt <= o_tick ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: rtl/lfsr_led_generator.sv
// Fibonacci LFSR stepped by prescaler tick or manual
// step edge, with LED mirror and advance counter.
module lfsr_led_generator
  import lfsr_pkg::*;
#(
  parameter int               WIDTH   = 31,
  parameter logic [WIDTH-1:0] TAPS    =
    WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED    = WIDTH'(1),
  parameter int               DIV     = 25_000_000,
  parameter                   LED_SEL = default_sel(WIDTH)
) (
  input logic             CLK_50M,
  input logic             RST,
  lfsr_led_generator_if.slave bus
);
  localparam int SW = sel_w(WIDTH);
  localparam logic [47:0] SEL = 48'(LED_SEL);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] ld_val;
  logic [31:0]      count;
  logic [7:0]       led;
  logic [7:0]       led_d;
  logic             step_q;
  logic             tick;
  logic             adv;
  logic             fb;

  tick_prescaler #(
    .DIV (DIV)
  ) u_presc (
    .CLK_50M (CLK_50M),
    .RST     (RST),
    .i_en    (bus.i_run),
    .o_tick  (tick)
  );

  assign fb  = ^(state & TAPS);
  assign adv = tick | (bus.i_step & ~step_q);

  // all-zero is a dead state; recover through SEED
  assign nxt = (state == '0) ? SEED
             : {state[WIDTH-2:0], fb};
  assign ld_val = (bus.i_seed == '0) ? SEED
                : bus.i_seed;

  for (genvar i = 0; i < LED_N; i++) begin : g_led
    localparam int F = int'(SEL[i*SW +: SW]);
    if (F < WIDTH) begin : g_on
      assign led_d[i] = state[F];
    end else begin : g_off
      assign led_d[i] = 1'b0;
    end
  end

  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      state  <= SEED;
      count  <= '0;
      led    <= '0;
      step_q <= 1'b0;
    end else begin
      step_q <= bus.i_step;
      led    <= led_d;
      priority case (1'b1)
        bus.i_load: begin
          state <= ld_val;
          count <= '0;
        end
        adv: begin
          state <= nxt;
          count <= count + 32'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.o_state  = state;
  assign bus.o_count  = count;
  assign bus.o_tick   = tick;
  assign bus.o_lockup = (state == '0);
  assign bus.LED      = led;
endmodule

// File: tb/tb_lfsr_led_generator.sv
// Scoreboard bench: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_lfsr_led_generator;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #10 clk = ~clk;

  lfsr_led_generator_if #(.WIDTH(31)) bus_a ();
  lfsr_led_generator_if #(.WIDTH(8))  bus_b ();

  lfsr_led_generator #(
    .WIDTH   (31),
    .DIV     (4),
    .LED_SEL ({5'd30, 5'd27, 5'd0, 5'd1,
               5'd2, 5'd3, 5'd4, 5'd31})
  ) u_a (
    .CLK_50M (clk),
    .RST     (rst),
    .bus     (bus_a)
  );

  lfsr_led_generator #(
    .WIDTH (8),
    .TAPS  (8'h00),
    .SEED  (8'h01),
    .DIV   (4)
  ) u_b (
    .CLK_50M (clk),
    .RST     (rst),
    .bus     (bus_b)
  );

  typedef struct {
    int          id;
    logic [63:0] st;
    logic [31:0] cnt;
    logic        lk;
    logic [7:0]  led;
    bit          cl;
    logic        tk;
    bit          ct;
  } exp_t;

  exp_t  q[$];
  string qn[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_tick = -1;
  bit tick_chk = 1'b0;

  task automatic push(
    input int          id,
    input string       nm,
    input logic [63:0] st,
    input logic [31:0] cnt,
    input logic        lk,
    input logic [7:0]  led,
    input bit          cl,
    input logic        tk,
    input bit          ct
  );
    exp_t e;
    e.id = id; e.st = st; e.cnt = cnt; e.lk = lk;
    e.led = led; e.cl = cl; e.tk = tk; e.ct = ct;
    q.push_back(e);
    qn.push_back(nm);
  endtask

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t        e;
    string       nm;
    logic [63:0] a_st;
    logic [31:0] a_cnt;
    logic        a_lk;
    logic [7:0]  a_led;
    logic        a_tk;
    bit          bad;
    cyc++;
    if (bus_a.o_tick) begin
      if (tick_chk && last_tick >= 0) begin
        checks++;
        if (cyc - last_tick != 4) begin
          errors++;
          $display("FAIL tick_gap got %0d want 4",
                   cyc - last_tick);
        end
      end
      last_tick = tick_chk ? cyc : -1;
    end
    while (q.size() > 0) begin
      e  = q.pop_front();
      nm = qn.pop_front();
      if (e.id == 0) begin
        a_st  = 64'(bus_a.o_state);
        a_cnt = bus_a.o_count;
        a_lk  = bus_a.o_lockup;
        a_led = bus_a.LED;
        a_tk  = bus_a.o_tick;
      end else begin
        a_st  = 64'(bus_b.o_state);
        a_cnt = bus_b.o_count;
        a_lk  = bus_b.o_lockup;
        a_led = bus_b.LED;
        a_tk  = bus_b.o_tick;
      end
      bad = (a_st !== e.st) || (a_cnt !== e.cnt)
         || (a_lk !== e.lk)
         || (e.cl && a_led !== e.led)
         || (e.ct && a_tk !== e.tk);
      checks++;
      if (bad) begin
        errors++;
        $display({"FAIL %s got st=%h cnt=%0d lk=%b",
                  " led=%b tk=%b want st=%h cnt=%0d",
                  " lk=%b led=%b tk=%b"},
                 nm, a_st, a_cnt, a_lk, a_led, a_tk,
                 e.st, e.cnt, e.lk, e.led, e.tk);
      end
    end
  end

  function automatic logic [30:0] nxt31(
    input logic [30:0] s
  );
    return {s[29:0], s[30] ^ s[27]};
  endfunction

  initial begin
    #200_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [30:0] s;
    logic [7:0]  led_tab [5];
    logic [63:0] eb;
    led_tab[0] = 8'h10; led_tab[1] = 8'h08;
    led_tab[2] = 8'h04; led_tab[3] = 8'h02;
    led_tab[4] = 8'h00;

    bus_a.i_run = 0; bus_a.i_step = 0;
    bus_a.i_load = 0; bus_a.i_seed = '0;
    bus_b.i_run = 0; bus_b.i_step = 0;
    bus_b.i_load = 0; bus_b.i_seed = '0;

    repeat (2) step_edge();
    push(0, "rst_a", 1, 0, 0, 8'h00, 1, 0, 1);
    push(1, "rst_b", 1, 0, 0, 8'h00, 1, 0, 1);

    // free run, DIV=4
    step_edge();
    rst = 0;
    bus_a.i_run = 1;
    tick_chk = 1;
    s = 31'd1;
    for (int k = 1; k <= 28; k++) begin
      repeat (4) step_edge();
      s = nxt31(s);
      if (k == 27)
        push(0, "adv27", 64'h0800_0000, 27, 0,
             8'h00, 0, 0, 1);
      else if (k == 28)
        push(0, "adv28", 64'h1000_0001, 28, 0,
             8'h40, 1, 0, 1);
      else
        push(0, "adv", 64'(s), k, 0,
             8'h00, 0, 0, 1);
    end
    tick_chk = 0;

    // async reset mid-count
    repeat (2) step_edge();
    #3;
    rst = 1;
    bus_a.i_run = 0;
    #1;
    push(0, "rst_mid", 1, 0, 0, 8'h00, 1, 0, 1);
    step_edge();
    rst = 0;

    // manual steps held 3 cycles
    for (int p = 1; p <= 5; p++) begin
      bus_a.i_step = 1;
      repeat (3) step_edge();
      bus_a.i_step = 0;
      repeat (2) step_edge();
      push(0, "man_step", 64'd1 << p, p, 0,
           led_tab[p-1], 1, 0, 1);
    end

    // load then LED selection one cycle later
    bus_a.i_load = 1;
    bus_a.i_seed = 31'h4800_000F;
    step_edge();
    bus_a.i_load = 0;
    bus_a.i_seed = '0;
    push(0, "load", 64'h4800_000F, 0, 0,
         8'h00, 1, 0, 1);
    step_edge();
    push(0, "led_sel", 64'h4800_000F, 0, 0,
         8'hFC, 1, 0, 1);

    // zero-seed load against a tick
    bus_a.i_run = 1;
    repeat (3) step_edge();
    push(0, "tick_hi", 64'h4800_000F, 0, 0,
         8'hFC, 1, 1, 1);
    bus_a.i_load = 1;
    step_edge();
    bus_a.i_load = 0;
    push(0, "ld_tick", 1, 0, 0, 8'hFC, 1, 0, 1);
    repeat (4) step_edge();
    push(0, "tick_adv", 2, 1, 0, 8'h00, 0, 0, 1);

    // step edge and tick together: one advance
    repeat (3) step_edge();
    bus_a.i_step = 1;
    step_edge();
    push(0, "step_tick", 4, 2, 0, 8'h00, 0, 0, 1);
    bus_a.i_step = 0;
    bus_a.i_run = 0;

    // zero-tap LFSR walks into lockup and recovers
    for (int k = 1; k <= 9; k++) begin
      bus_b.i_step = 1;
      step_edge();
      bus_b.i_step = 0;
      step_edge();
      eb = (k == 9) ? 64'd1
         : (k == 8) ? 64'd0 : (64'd1 << k);
      push(1, "b_step", eb, k, (k == 8),
           eb[7:0], 1, 0, 1);
    end

    step_edge();
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d want 0",
               q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
